// File: rtl/adventure_room_fsm_if.sv
// Player-side signal bundle for the room-navigation FSM: raw direction buttons and
// the sword-holder feedback in, room and status out.
interface adventure_room_fsm_if #(
    parameter int MOVE_W = 6
);
    logic              n;
    logic              s;
    logic              e;
    logic              w;
    logic              v;
    logic              sw;
    logic [6:0]        room;
    logic              win;
    logic              dead;
    logic [MOVE_W-1:0] moves;

    modport master (
        output n, s, e, w, v,
        input  sw, room, win, dead, moves
    );

    modport slave (
        input  n, s, e, w, v,
        output sw, room, win, dead, moves
    );
endinterface

// File: rtl/adventure_room_fsm.sv
// Room-navigation FSM: edge-detects the direction buttons, walks a one-hot room map,
// resolves the dragon den from the vorpal-sword input and counts accepted moves.
module adventure_room_fsm #(
    parameter int MOVE_W = 6
) (
    input  logic                 clk,
    input  logic                 reset,
    adventure_room_fsm_if.slave  bus
);
    typedef enum logic [6:0] {
        CAVE   = 7'b0000001,
        TUNNEL = 7'b0000010,
        RIVER  = 7'b0000100,
        STASH  = 7'b0001000,
        DEN    = 7'b0010000,
        VAULT  = 7'b0100000,
        GRAVE  = 7'b1000000
    } room_t;

    localparam logic [MOVE_W-1:0] MOVES_MAX = '1;

    // Button vector ordering: [3]=n [2]=s [1]=e [0]=w
    logic [3:0]        btn;
    logic [3:0]        btn_prev_reg;
    logic [3:0]        press;
    logic              move_req;

    room_t             room_reg;
    room_t             room_next;
    logic [MOVE_W-1:0] moves_reg;
    logic [MOVE_W-1:0] moves_next;
    logic              accepted;
    logic              sw_reg;
    logic              win_reg;
    logic              dead_reg;

    assign btn = {bus.n, bus.s, bus.e, bus.w};

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_press
            assign press[gi] = btn[gi] & ~btn_prev_reg[gi];
        end
    endgenerate

    // Simultaneous presses are ambiguous and therefore dropped entirely.
    assign move_req = ($countones(press) == 1);

    always_comb begin
        room_next = room_reg;
        accepted  = 1'b0;
        case (room_reg)
            CAVE: begin
                if (move_req && press[1]) begin
                    room_next = TUNNEL;
                    accepted  = 1'b1;
                end
            end
            TUNNEL: begin
                if (move_req && press[0]) begin
                    room_next = CAVE;
                    accepted  = 1'b1;
                end else if (move_req && press[2]) begin
                    room_next = RIVER;
                    accepted  = 1'b1;
                end
            end
            RIVER: begin
                if (move_req && press[3]) begin
                    room_next = TUNNEL;
                    accepted  = 1'b1;
                end else if (move_req && press[0]) begin
                    room_next = STASH;
                    accepted  = 1'b1;
                end else if (move_req && press[1]) begin
                    room_next = DEN;
                    accepted  = 1'b1;
                end
            end
            STASH: begin
                if (move_req && press[1]) begin
                    room_next = RIVER;
                    accepted  = 1'b1;
                end
            end
            // The den is left automatically after one cycle and is not a move.
            DEN:     room_next = bus.v ? VAULT : GRAVE;
            VAULT:   room_next = VAULT;
            GRAVE:   room_next = GRAVE;
            default: room_next = CAVE;
        endcase
    end

    always_comb begin
        moves_next = moves_reg;
        if (accepted && (moves_reg != MOVES_MAX)) begin
            moves_next = moves_reg + 1'b1;
        end
    end

    // Status flags are registered from room_next so they line up with room_reg.
    always_ff @(posedge clk) begin
        if (!reset) begin
            room_reg     <= CAVE;
            btn_prev_reg <= 4'b1111;
            moves_reg    <= '0;
            sw_reg       <= 1'b0;
            win_reg      <= 1'b0;
            dead_reg     <= 1'b0;
        end else begin
            room_reg     <= room_next;
            btn_prev_reg <= btn;
            moves_reg    <= moves_next;
            sw_reg       <= (room_next == STASH);
            win_reg      <= (room_next == VAULT);
            dead_reg     <= (room_next == GRAVE);
        end
    end

    assign bus.room  = room_reg;
    assign bus.moves = moves_reg;
    assign bus.sw    = sw_reg;
    assign bus.win   = win_reg;
    assign bus.dead  = dead_reg;
endmodule
